// File: rtl/sdp_bram_arb_pkg.sv
// Shared types for the arbitrated simple-dual-port BRAM controller.
package sdp_bram_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port block RAM: one write port, one registered read port.
// Contents have no reset; a same-address read returns the old word.
module sdp_bram #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] rd
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/sdp_bram_arb.sv
// Clears an sdp_bram after reset, then shares its read port between two
// requesters round-robin, with write-first bypass on same-cycle collisions.
module sdp_bram_arb
  import sdp_bram_arb_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 6,
  parameter int unsigned          DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_done,
  input  logic                  w_valid,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_ready,
  input  logic                  r0_valid,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  output logic                  r0_ready,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_valid,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic                  r1_ready,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  prio;
  logic                  hit;
  logic [DATA_WIDTH-1:0] byp_data;

  logic                  run;
  logic                  grant0;
  logic                  grant1;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_wa;
  logic [DATA_WIDTH-1:0] ram_wd;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_ra;
  logic [DATA_WIDTH-1:0] ram_rd;
  logic [DATA_WIDTH-1:0] ret_data;

  // Round-robin grant; nothing is granted while reset is asserted.
  assign run    = (state == ST_RUN) && !reset;
  assign grant0 = run && r0_valid && (!r1_valid || (prio == 1'b0));
  assign grant1 = run && r1_valid && (!r0_valid || (prio == 1'b1));

  assign r0_ready = grant0;
  assign r1_ready = grant1;
  assign w_ready  = init_done;

  // RAM port muxing: the clear sweep owns the write port until RUN.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = w_addr;
    ram_wd = w_data;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        ram_we = 1'b1;
        ram_wa = clr_cnt;
        ram_wd = CLEAR_VAL;
      end else begin
        ram_we = w_valid;
      end
    end
  end

  assign ram_re = grant0 || grant1;
  assign ram_ra = grant1 ? r1_addr : r0_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      prio      <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      hit       <= 1'b0;
      byp_data  <= '0;
    end else begin
      r0_rvalid <= grant0;
      r1_rvalid <= grant1;
      hit       <= ram_re && (state == ST_RUN) && w_valid && (w_addr == ram_ra);
      byp_data  <= w_data;
      case (state)
        ST_CLEAR: begin
          clr_cnt <= ADDR_WIDTH'(clr_cnt + 1'b1);
          if (clr_cnt == LAST_ADDR) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (grant0)      prio <= 1'b1;
          else if (grant1) prio <= 1'b0;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Write-first: a colliding write seen at grant time wins over the array.
  assign ret_data = hit ? byp_data : ram_rd;
  assign r0_rdata = ret_data;
  assign r1_rdata = ret_data;

  sdp_bram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk(clk),
    .we (ram_we),
    .wa (ram_wa),
    .wd (ram_wd),
    .re (ram_re),
    .ra (ram_ra),
    .rd (ram_rd)
  );

endmodule

// File: tb/tb_sdp_bram_arb.sv
// Directed bench for sdp_bram_arb: clear sweep, arbitration, bypass, reset.
module tb_sdp_bram_arb;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 64;
  localparam logic [DW-1:0] CV = 64'hDEAD;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_done;
  logic          w_valid;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          r0_valid;
  logic [AW-1:0] r0_addr;
  logic          r0_ready;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;
  logic          r1_valid;
  logic [AW-1:0] r1_addr;
  logic          r1_ready;
  logic          r1_rvalid;
  logic [DW-1:0] r1_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdp_bram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VAL(CV)) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(r0_ready),
    .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(r1_ready),
    .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    w_valid = 1'b1; w_addr = a; w_data = d;
    step();
    w_valid = 1'b0;
  endtask

  task automatic rd0(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    r0_valid = 1'b1; r0_addr = a;
    #1;
    chk({tag, "_ready"}, 64'(r0_ready), 64'd1);
    step();
    r0_valid = 1'b0;
    chk({tag, "_rvalid"}, 64'(r0_rvalid), 64'd1);
    chk({tag, "_rdata"}, r0_rdata, exp);
    chk({tag, "_r1_quiet"}, 64'(r1_rvalid), 64'd0);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 200) begin
      step();
      n++;
    end
    chk(tag, 64'(n), 64'd64);
  endtask

  initial begin
    reset = 1'b1; w_valid = 1'b0; w_addr = '0; w_data = '0;
    r0_valid = 1'b0; r0_addr = '0; r1_valid = 1'b0; r1_addr = '0;
    #1;
    repeat (3) step();
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_r0_rvalid", 64'(r0_rvalid), 64'd0);
    chk("rst_r1_rvalid", 64'(r1_rvalid), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);

    // Sweep: requests are refused while clearing.
    reset = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    chk("clr_r0_ready", 64'(r0_ready), 64'd0);
    chk("clr_r1_ready", 64'(r1_ready), 64'd0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_init("init_edges");
    chk("run_w_ready", 64'(w_ready), 64'd1);

    rd0("clr0", 6'd0, CV);
    rd0("clr17", 6'd17, CV);
    rd0("clr63", 6'd63, CV);

    wr(6'd5, 64'h1234);
    rd0("wr5", 6'd5, 64'h1234);

    // Collision: r1 reads 9 while 9 is rewritten; new data must return.
    wr(6'd9, 64'h55);
    r1_valid = 1'b1; r1_addr = 6'd9;
    w_valid = 1'b1; w_addr = 6'd9; w_data = 64'hAA;
    #1;
    chk("coll_r1_ready", 64'(r1_ready), 64'd1);
    step();
    r1_valid = 1'b0;
    w_valid = 1'b1; w_addr = 6'd9; w_data = 64'hBB;
    chk("coll_rvalid", 64'(r1_rvalid), 64'd1);
    chk("coll_rdata", r1_rdata, 64'hAA);
    step();
    w_valid = 1'b0;
    chk("coll_rvalid_drop", 64'(r1_rvalid), 64'd0);

    // Alternating grants; prio is 0 after the r1 grant above.
    wr(6'd1, 64'h111);
    wr(6'd2, 64'h222);
    r0_valid = 1'b1; r0_addr = 6'd1;
    r1_valid = 1'b1; r1_addr = 6'd2;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("alt%0d_r0_ready", i), 64'(r0_ready), 64'((i % 2) == 0));
      chk($sformatf("alt%0d_r1_ready", i), 64'(r1_ready), 64'((i % 2) == 1));
      step();
      chk($sformatf("alt%0d_r0_rvalid", i), 64'(r0_rvalid), 64'((i % 2) == 0));
      chk($sformatf("alt%0d_r1_rvalid", i), 64'(r1_rvalid), 64'((i % 2) == 1));
      chk($sformatf("alt%0d_rdata", i), ((i % 2) == 0) ? r0_rdata : r1_rdata,
          ((i % 2) == 0) ? 64'h111 : 64'h222);
    end
    r0_valid = 1'b0;

    // r1 alone is granted every cycle.
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("solo%0d_r1_ready", i), 64'(r1_ready), 64'd1);
      step();
      chk($sformatf("solo%0d_r1_rvalid", i), 64'(r1_rvalid), 64'd1);
      chk($sformatf("solo%0d_rdata", i), r1_rdata, 64'h222);
    end
    r0_valid = 1'b1;
    #1;
    chk("both_r0_ready", 64'(r0_ready), 64'd1);
    chk("both_r1_ready", 64'(r1_ready), 64'd0);
    step();
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("both_r0_rvalid", 64'(r0_rvalid), 64'd1);
    chk("both_r1_rvalid", 64'(r1_rvalid), 64'd0);
    chk("both_rdata", r0_rdata, 64'h111);

    // In-flight rvalid is cancelled by reset.
    wr(6'd3, 64'h77);
    wr(6'd40, 64'h88);
    r0_valid = 1'b1; r0_addr = 6'd3;
    step();
    r0_valid = 1'b0;
    reset = 1'b1;
    chk("pre_rst_rvalid", 64'(r0_rvalid), 64'd1);
    step();
    chk("cancel_rvalid", 64'(r0_rvalid), 64'd0);
    chk("rst2_init_done", 64'(init_done), 64'd0);

    // Reset again 30 cycles into the sweep; sweep restarts from address 0.
    reset = 1'b0;
    repeat (30) step();
    chk("mid_init_done", 64'(init_done), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_init("reinit_edges");
    rd0("reclr3", 6'd3, CV);
    rd0("reclr40", 6'd40, CV);
    rd0("reclr5", 6'd5, CV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
